// File: rtl/tile_step_ctrl.sv
// Piano Tiles step controller: holds the tile rows, sequences draw/wait/judge/score/scroll.
// Optional TILE_LIVES_EN: 3-life mode with an extra lives[1:0] output.
module tile_step_ctrl #(
  parameter int          ROWS = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [3:0]        key_n,
  input  logic              wait_done,
  input  logic              draw_ack,
  output logic              wait_go,
  output logic              draw_req,
  output logic [4*ROWS-1:0] tiles,
  output logic [23:0]       Q,
`ifdef TILE_LIVES_EN
  output logic [1:0]        lives,
`endif
  output logic              game_over
);

  localparam int CW = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAW, S_WAIT, S_CHECK, S_SHIFT, S_OVER
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;
  logic [3:0]    key_prev;
  logic [3:0]    press;
  logic [3:0]    new_row;
  logic [CW-1:0] row_cnt;
  logic          hit, miss;
  logic [24:0]   q_sum;
  logic [23:0]   q_inc;

  assign press    = key_prev & ~key_n;
  assign new_row  = 4'b0001 << lfsr[1:0];
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign q_sum    = {1'b0, Q} + 25'd1;
  assign q_inc    = q_sum[24] ? 24'hFFFFFF : q_sum[23:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      key_prev  <= 4'hF;
      row_cnt   <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      wait_go   <= 1'b0;
      draw_req  <= 1'b0;
      tiles     <= '0;
      Q         <= '0;
      game_over <= 1'b0;
`ifdef TILE_LIVES_EN
      lives     <= 2'd0;
`endif
    end else begin
      key_prev <= key_n;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state     <= S_LOAD;
            Q         <= '0;
            row_cnt   <= '0;
            game_over <= 1'b0;
`ifdef TILE_LIVES_EN
            lives     <= 2'd3;
`endif
          end
        end
        S_LOAD: begin
          // First generated row ends up at row 0 after ROWS shifts.
          tiles   <= {new_row, tiles[4*ROWS-1:4]};
          lfsr    <= lfsr_nxt;
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == CW'(ROWS - 1)) begin
            state    <= S_DRAW;
            draw_req <= 1'b1;
          end
        end
        S_DRAW: begin
          if (draw_ack) begin
            state    <= S_WAIT;
            draw_req <= 1'b0;
            wait_go  <= 1'b1;
            hit      <= 1'b0;
            miss     <= 1'b0;
          end
        end
        S_WAIT: begin
          // Any press after the first one in a step, or a multi-key press, is a miss.
          if (|press) begin
            if (press == tiles[3:0] && !hit && !miss) hit  <= 1'b1;
            else                                      miss <= 1'b1;
          end
          if (wait_done) begin
            state   <= S_CHECK;
            wait_go <= 1'b0;
          end
        end
        S_CHECK: begin
          if (hit && !miss) begin
            Q     <= q_inc;
            state <= S_SHIFT;
          end else begin
`ifdef TILE_LIVES_EN
            if (lives <= 2'd1) begin
              lives     <= 2'd0;
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              lives <= lives - 2'd1;
              state <= S_SHIFT;
            end
`else
            state     <= S_OVER;
            game_over <= 1'b1;
`endif
          end
        end
        S_SHIFT: begin
          tiles    <= {new_row, tiles[4*ROWS-1:4]};
          lfsr     <= lfsr_nxt;
          state    <= S_DRAW;
          draw_req <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_step_ctrl.sv
// Directed self-checking bench for tile_step_ctrl (ROWS=4, SEED=16'hACE1).
module tb_tile_step_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic        wait_done = 1'b0;
  logic        draw_ack = 1'b0;
  logic        wait_go, draw_req, game_over;
  logic [15:0] tiles;
  logic [23:0] Q;
`ifdef TILE_LIVES_EN
  logic [1:0]  lives;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] exp_tiles;

  tile_step_ctrl #(.ROWS(4), .SEED(16'hACE1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .key_n(key_n),
    .wait_done(wait_done), .draw_ack(draw_ack), .wait_go(wait_go),
    .draw_req(draw_req), .tiles(tiles), .Q(Q),
`ifdef TILE_LIVES_EN
    .lives(lives),
`endif
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lane_oh(input logic [1:0] l);
    case (l)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] t);
    return {t[2:0], t[3]};
  endfunction

  // Reference row generator: tap mask 0xB400 selects bits 15,13,12,10.
  task automatic model_row();
    exp_tiles = {lane_oh(m_lfsr[1:0]), exp_tiles[15:4]};
    m_lfsr    = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_load();
    repeat (4) begin model_row(); tick(); end
  endtask

  task automatic do_draw();
    draw_ack = 1'b1; tick(); draw_ack = 1'b0;
  endtask

  task automatic do_press(input logic [3:0] k);
    key_n = k; tick(); key_n = 4'hF; tick();
  endtask

  task automatic finish_wait();
    wait_done = 1'b1; tick(); wait_done = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick(); tick();
    checks++; if (draw_req !== 1'b0) begin errors++; $display("FAIL reset_draw_req: got %b want 0", draw_req); end
    checks++; if (wait_go !== 1'b0) begin errors++; $display("FAIL reset_wait_go: got %b want 0", wait_go); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    checks++; if (tiles !== 16'h0) begin errors++; $display("FAIL reset_tiles: got %h want 0000", tiles); end
    checks++; if (Q !== 24'h0) begin errors++; $display("FAIL reset_q: got %h want 000000", Q); end
`ifdef TILE_LIVES_EN
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL reset_lives: got %0d want 0", lives); end
`endif
    resetn = 1'b1;
    m_lfsr = 16'hACE1; exp_tiles = 16'h0;
  endtask

  task automatic test_load();
    do_start();
    repeat (3) begin model_row(); tick(); end
    checks++; if (draw_req !== 1'b0) begin errors++; $display("FAIL load_draw_early: got %b want 0", draw_req); end
    checks++; if (tiles !== exp_tiles) begin errors++; $display("FAIL load_partial: got %h want %h", tiles, exp_tiles); end
    model_row(); tick();
    checks++; if (draw_req !== 1'b1) begin errors++; $display("FAIL load_draw_req: got %b want 1", draw_req); end
    checks++; if (tiles !== 16'h8882) begin errors++; $display("FAIL load_tiles: got %h want 8882", tiles); end
  endtask

  task automatic test_step();
    do_draw();
    checks++; if (wait_go !== 1'b1 || draw_req !== 1'b0) begin errors++; $display("FAIL step_wait_entry: got go=%b req=%b want go=1 req=0", wait_go, draw_req); end
    do_press(~exp_tiles[3:0]);
    finish_wait();
    checks++; if (wait_go !== 1'b0) begin errors++; $display("FAIL step_check_go: got %b want 0", wait_go); end
    tick();
    checks++; if (Q !== 24'd1) begin errors++; $display("FAIL step_q: got %0d want 1", Q); end
    model_row(); tick();
    checks++; if (tiles !== exp_tiles) begin errors++; $display("FAIL step_shift: got %h want %h", tiles, exp_tiles); end
    checks++; if (draw_req !== 1'b1 || wait_go !== 1'b0) begin errors++; $display("FAIL step_redraw: got req=%b go=%b want req=1 go=0", draw_req, wait_go); end
  endtask

  task automatic test_wrong_lane();
    logic [15:0] held;
    do_draw();
    do_press(~rot(exp_tiles[3:0]));
    finish_wait(); tick();
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL wrong_over: got %b want 1", game_over); end
    held = exp_tiles;
    start = 1'b0; tick(); tick();
    checks++; if (Q !== 24'd1 || tiles !== held) begin errors++; $display("FAIL wrong_frozen: got q=%0d t=%h want q=1 t=%h", Q, tiles, held); end
  endtask

  task automatic test_no_press();
    do_start();
    checks++; if (Q !== 24'd0 || game_over !== 1'b0) begin errors++; $display("FAIL restart: got q=%0d over=%b want q=0 over=0", Q, game_over); end
    do_load(); do_draw();
    tick(); tick();
    finish_wait(); tick();
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL nopress_over: got %b want 1", game_over); end
  endtask

  task automatic test_multi_press();
    do_start(); do_load(); do_draw();
    do_press(~(exp_tiles[3:0] | rot(exp_tiles[3:0])));
    finish_wait(); tick();
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL multi_same_cycle: got %b want 1", game_over); end
    do_start(); do_load(); do_draw();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (wait_go !== 1'b1 || Q !== 24'd0) begin errors++; $display("FAIL start_ignored: got go=%b q=%0d want go=1 q=0", wait_go, Q); end
    do_press(~exp_tiles[3:0]);
    do_press(~rot(exp_tiles[3:0]));
    finish_wait(); tick();
    checks++; if (game_over !== 1'b1 || Q !== 24'd0) begin errors++; $display("FAIL second_press: got over=%b q=%0d want over=1 q=0", game_over, Q); end
  endtask

  // draw_ack held high (same-cycle ack) and key pressed on the wait_done edge.
  task automatic test_back_to_back();
    do_start(); do_load();
    draw_ack = 1'b1;
    repeat (2) begin
      tick();
      key_n = ~exp_tiles[3:0]; wait_done = 1'b1; tick();
      key_n = 4'hF; wait_done = 1'b0;
      tick(); model_row(); tick();
    end
    draw_ack = 1'b0;
    checks++; if (Q !== 24'd2) begin errors++; $display("FAIL b2b_q: got %0d want 2", Q); end
    checks++; if (tiles !== exp_tiles || draw_req !== 1'b1) begin errors++; $display("FAIL b2b_tiles: got %h req=%b want %h req=1", tiles, draw_req, exp_tiles); end
  endtask

  task automatic test_reset_midway();
    resetn = 1'b0; tick(); resetn = 1'b1;
    checks++; if (draw_req !== 1'b0 || Q !== 24'd0 || tiles !== 16'h0) begin errors++; $display("FAIL reset_draw: got req=%b q=%0d t=%h want 0", draw_req, Q, tiles); end
    m_lfsr = 16'hACE1; exp_tiles = 16'h0;
    do_start(); tick(); tick();
    resetn = 1'b0; tick(); resetn = 1'b1;
    checks++; if (tiles !== 16'h0) begin errors++; $display("FAIL reset_midload: got %h want 0000", tiles); end
    m_lfsr = 16'hACE1; exp_tiles = 16'h0;
    do_start(); do_load();
    checks++; if (tiles !== 16'h8882) begin errors++; $display("FAIL reload_seed: got %h want 8882", tiles); end
  endtask

`ifdef TILE_LIVES_EN
  task automatic test_lives();
    do_start();
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL lives_load: got %0d want 3", lives); end
    do_load();
    for (int i = 2; i >= 1; i--) begin
      do_draw(); finish_wait(); tick();
      checks++; if (lives !== 2'(i) || game_over !== 1'b0) begin errors++; $display("FAIL lives_dec: got %0d over=%b want %0d", lives, game_over, i); end
      model_row(); tick();
    end
    do_draw(); finish_wait(); tick();
    checks++; if (lives !== 2'd0 || game_over !== 1'b1) begin errors++; $display("FAIL lives_over: got %0d over=%b want 0 over=1", lives, game_over); end
    do_start(); do_load();
    force dut.Q = 24'hFFFFFE; #1; release dut.Q;
    repeat (2) begin
      do_draw(); do_press(~exp_tiles[3:0]); finish_wait(); tick(); model_row(); tick();
    end
    checks++; if (Q !== 24'hFFFFFF) begin errors++; $display("FAIL q_saturate: got %h want ffffff", Q); end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_load();
    test_step();
`ifdef TILE_LIVES_EN
    test_lives();
`else
    test_wrong_lane();
    test_no_press();
    test_multi_press();
    test_back_to_back();
    test_reset_midway();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
